// File: rtl/lock_ctrl.sv
// Keypad-side sequencer for the doorlock datapath: turns key events into buffer strobes,
// runs the keypad shuffle, and decides unlock, password registration and lockout.
module lock_ctrl #(
  parameter int SHUFFLE_STEPS = 8,
  parameter int OPEN_CYCLES   = 1000,
  parameter int LOCK_CYCLES   = 5000,
  parameter int IDLE_TIMEOUT  = 3000,
  parameter int MAX_FAILS     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       star_key,
  input  logic       same,
  input  logic       master_same,
  input  logic       limit,
  input  logic       long_confirm,
  output logic       input_v,
  output logic       decision,
  output logic       buff_rst,
  output logic       mem_rst,
  output logic       star,
  output logic       shuffle_init,
  output logic [3:0] index_A,
  output logic [3:0] index_B,
  output logic       door_open,
  output logic       alarm
);

  localparam int TMAX_A = (SHUFFLE_STEPS > OPEN_CYCLES) ? SHUFFLE_STEPS : OPEN_CYCLES;
  localparam int TMAX_B = (LOCK_CYCLES > IDLE_TIMEOUT) ? LOCK_CYCLES : IDLE_TIMEOUT;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int FW     = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [TW-1:0] SHUF_LAST = TW'(SHUFFLE_STEPS - 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(IDLE_TIMEOUT - 1);
  localparam logic [FW-1:0] F_ONE     = FW'(1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_IDLE, S_SHUFFLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT, S_REG_CLR, S_REG
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          star_q, star_d;
  logic          lc_seen_q, lc_seen_d;
  logic          pend_q, pend_d;
  logic          input_v_q, input_v_d;
  logic          decision_q, decision_d;
  logic          buff_rst_q, buff_rst_d;
  logic          mem_rst_q, mem_rst_d;
  logic          shuffle_init_q, shuffle_init_d;
  logic [3:0]    idx_a_q, idx_a_d;
  logic [3:0]    idx_b_q, idx_b_d;
  logic          door_q, door_d;
  logic          alarm_q, alarm_d;
  logic          star_fall;
  logic          active;

  assign star_fall = star_q & ~star_key;
  assign active    = key_press | star_key;

  always_comb begin
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    star_d         = star_key;
    state_d        = state_q;
    timer_d        = timer_q;
    fail_d         = fail_q;
    // A star release that follows a long press belongs to that long press, not to a check.
    lc_seen_d      = lc_seen_q & star_key;
    pend_d         = 1'b0;
    input_v_d      = 1'b0;
    buff_rst_d     = 1'b0;
    mem_rst_d      = 1'b0;
    shuffle_init_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_press && !buff_rst_q) begin
          state_d        = S_SHUFFLE;
          timer_d        = '0;
          buff_rst_d     = 1'b1;
          shuffle_init_d = 1'b1;
        end
      end
      S_SHUFFLE: begin
        if (timer_q == SHUF_LAST) begin
          state_d = S_ENTRY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_ENTRY, S_REG: begin
        timer_d = active ? '0 : timer_q + T_ONE;
        if (state_q == S_ENTRY && long_confirm && master_same) begin
          state_d    = S_REG_CLR;
          timer_d    = '0;
          lc_seen_d  = 1'b1;
          mem_rst_d  = 1'b1;
          buff_rst_d = 1'b1;
        end else if (pend_q || (star_fall && !lc_seen_q && !key_press)) begin
          state_d = (state_q == S_ENTRY) ? S_CHECK : S_IDLE;
          timer_d = '0;
        end else begin
          // A digit arriving with the star release is taken first; the release acts next cycle.
          input_v_d = key_press & ~limit & ~input_v_q;
          pend_d    = star_fall & key_press & ~lc_seen_q;
          if (state_q == S_ENTRY && long_confirm) begin
            lc_seen_d = 1'b1;
          end
          if (timer_q == TO_LAST && !active) begin
            state_d    = S_IDLE;
            timer_d    = '0;
            buff_rst_d = 1'b1;
          end
        end
      end
      S_CHECK: begin
        buff_rst_d = 1'b1;
        timer_d    = '0;
        if (same || master_same) begin
          fail_d  = '0;
          state_d = S_OPEN;
        end else begin
          fail_d  = fail_q + F_ONE;
          state_d = (fail_d == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_OPEN: begin
        if (timer_q == OPEN_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      S_REG_CLR: begin
        state_d = S_REG;
        timer_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    decision_d = (state_d == S_REG);
    door_d     = (state_d == S_OPEN);
    alarm_d    = (state_d == S_LOCKOUT);
    idx_a_d    = (state_d == S_SHUFFLE) ? lfsr_d[3:0] : 4'd0;
    idx_b_d    = (state_d == S_SHUFFLE) ? lfsr_d[7:4] : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      fail_q         <= '0;
      lfsr_q         <= 8'hA5;
      star_q         <= 1'b0;
      lc_seen_q      <= 1'b0;
      pend_q         <= 1'b0;
      input_v_q      <= 1'b0;
      decision_q     <= 1'b0;
      buff_rst_q     <= 1'b0;
      mem_rst_q      <= 1'b0;
      shuffle_init_q <= 1'b0;
      idx_a_q        <= 4'd0;
      idx_b_q        <= 4'd0;
      door_q         <= 1'b0;
      alarm_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      fail_q         <= fail_d;
      lfsr_q         <= lfsr_d;
      star_q         <= star_d;
      lc_seen_q      <= lc_seen_d;
      pend_q         <= pend_d;
      input_v_q      <= input_v_d;
      decision_q     <= decision_d;
      buff_rst_q     <= buff_rst_d;
      mem_rst_q      <= mem_rst_d;
      shuffle_init_q <= shuffle_init_d;
      idx_a_q        <= idx_a_d;
      idx_b_q        <= idx_b_d;
      door_q         <= door_d;
      alarm_q        <= alarm_d;
    end
  end

  assign input_v      = input_v_q;
  assign decision     = decision_q;
  assign buff_rst     = buff_rst_q;
  assign mem_rst      = mem_rst_q;
  assign star         = star_q;
  assign shuffle_init = shuffle_init_q;
  assign index_A      = idx_a_q;
  assign index_B      = idx_b_q;
  assign door_open    = door_q;
  assign alarm        = alarm_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Scenario bench for lock_ctrl: a small model tracks the LFSR sequence and the
// consecutive-fail count, and each task checks one behaviour of the sequencer.
module tb_lock_ctrl;

  localparam int STEPS  = 8;
  localparam int OPEN_N = 1000;
  localparam int LOCK_N = 5000;
  localparam int TO_N   = 3000;
  localparam int MAXF   = 3;

  logic clk = 1'b0;
  logic rst, key_press, star_key, same, master_same, limit, long_confirm;
  logic input_v, decision, buff_rst, mem_rst, star, shuffle_init, door_open, alarm;
  logic [3:0] index_A, index_B;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_iv = 0, cnt_br = 0, cnt_mr = 0, cnt_si = 0;
  logic [3:0] prev_pulse = 4'd0;
  logic [7:0] lfsr_m = 8'hA5;
  int fails_m = 0;

  lock_ctrl dut (
    .clk(clk), .rst(rst), .key_press(key_press), .star_key(star_key), .same(same),
    .master_same(master_same), .limit(limit), .long_confirm(long_confirm),
    .input_v(input_v), .decision(decision), .buff_rst(buff_rst), .mem_rst(mem_rst),
    .star(star), .shuffle_init(shuffle_init), .index_A(index_A), .index_B(index_B),
    .door_open(door_open), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // x^8+x^6+x^5+x^4+1, shifted towards the MSB
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic tick();
    logic [3:0] cur;
    @(posedge clk);
    lfsr_m = rst ? 8'hA5 : lfsr_next(lfsr_m);
    #1;
    cur = {input_v, buff_rst, mem_rst, shuffle_init};
    if (prev_pulse != 4'd0) begin
      n_chk++;
      if ((cur & prev_pulse) != 4'd0) begin
        n_fail++;
        $display("FAIL pulse_repeat: {iv,br,mr,si} now %b after %b, required no overlap", cur, prev_pulse);
      end
    end
    prev_pulse = cur;
    if (input_v === 1'b1) cnt_iv++;
    if (buff_rst === 1'b1) cnt_br++;
    if (mem_rst === 1'b1) cnt_mr++;
    if (shuffle_init === 1'b1) cnt_si++;
  endtask

  task automatic press_key();
    key_press = 1'b1; tick(); key_press = 1'b0; tick();
  endtask

  task automatic enter_entry();
    tick(); tick();
    key_press = 1'b1; tick(); key_press = 1'b0;
    repeat (STEPS) tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_chk++;
    if ({input_v, decision, buff_rst, mem_rst, star, shuffle_init, door_open, alarm} !== 8'h00 ||
        index_A !== 4'd0 || index_B !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b idxA=%h idxB=%h, required all zero",
               {input_v, decision, buff_rst, mem_rst, star, shuffle_init, door_open, alarm}, index_A, index_B);
    end
    rst = 1'b0;
  endtask

  task automatic test_shuffle();
    int si0;
    si0 = cnt_si;
    tick(); tick();
    key_press = 1'b1; tick(); key_press = 1'b0;
    n_chk++;
    if (shuffle_init !== 1'b1 || buff_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL shuffle_start: shuffle_init=%b buff_rst=%b, required 1 1", shuffle_init, buff_rst);
    end
    for (int i = 0; i < STEPS; i++) begin
      n_chk++;
      if (index_A !== lfsr_m[3:0] || index_B !== lfsr_m[7:4]) begin
        n_fail++;
        $display("FAIL shuffle_index step %0d: A=%h B=%h, required A=%h B=%h", i, index_A, index_B, lfsr_m[3:0], lfsr_m[7:4]);
      end
      tick();
    end
    n_chk++;
    if (index_A !== 4'd0 || index_B !== 4'd0 || cnt_si - si0 !== 1) begin
      n_fail++;
      $display("FAIL shuffle_end: A=%h B=%h inits=%0d, required 0 0 1", index_A, index_B, cnt_si - si0);
    end
  endtask

  task automatic test_timeout(input bit do_enter);
    int n;
    if (do_enter) enter_entry();
    n = 0;
    while (buff_rst !== 1'b1 && n < TO_N + 100) begin
      tick();
      n++;
    end
    n_chk++;
    if (n !== TO_N) begin
      n_fail++;
      $display("FAIL entry_timeout: buff_rst after %0d idle cycles, required %0d", n, TO_N);
    end
  endtask

  task automatic run_attempt(input logic s, input logic ms, input int ndig, input int open_stop);
    int iv0, si0, cyc;
    bit exp_open, exp_alarm;
    enter_entry();
    iv0 = cnt_iv;
    for (int i = 0; i < ndig; i++) press_key();
    n_chk++;
    if (cnt_iv - iv0 !== ndig) begin
      n_fail++;
      $display("FAIL entry_digits: %0d input_v, required %0d", cnt_iv - iv0, ndig);
    end
    same = s; master_same = ms;
    star_key = 1'b1; tick();
    star_key = 1'b0; tick();
    tick();
    same = 1'b0; master_same = 1'b0;

    exp_open = s | ms;
    if (exp_open) fails_m = 0;
    else fails_m++;
    exp_alarm = (fails_m == MAXF);
    n_chk++;
    if (door_open !== exp_open || alarm !== exp_alarm || buff_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL check_outcome: door=%b alarm=%b buff_rst=%b, required %b %b 1",
               door_open, alarm, buff_rst, exp_open, exp_alarm);
    end

    iv0 = cnt_iv; si0 = cnt_si; cyc = 0;
    if (exp_open) begin
      while (door_open === 1'b1 && cyc < open_stop) begin
        cyc++;
        key_press = (cyc == 300);
        tick();
        key_press = 1'b0;
      end
      if (open_stop > OPEN_N) begin
        n_chk++;
        if (cyc !== OPEN_N || cnt_iv !== iv0 || cnt_si !== si0) begin
          n_fail++;
          $display("FAIL open_window: door high %0d cycles, iv=%0d si=%0d, required %0d 0 0",
                   cyc, cnt_iv - iv0, cnt_si - si0, OPEN_N);
        end
      end
    end else if (exp_alarm) begin
      while (alarm === 1'b1 && cyc < LOCK_N + 200) begin
        cyc++;
        key_press = (cyc % 100 == 50);
        tick();
        key_press = 1'b0;
      end
      fails_m = 0;
      n_chk++;
      if (cyc !== LOCK_N || cnt_iv !== iv0 || cnt_si !== si0) begin
        n_fail++;
        $display("FAIL lockout_window: alarm high %0d cycles, iv=%0d si=%0d, required %0d 0 0",
                 cyc, cnt_iv - iv0, cnt_si - si0, LOCK_N);
      end
    end
  endtask

  task automatic test_unlock();
    run_attempt(1'b1, 1'b0, 4, OPEN_N + 200);
  endtask

  task automatic test_lockout();
    logic r;
    r = 1'($urandom_range(0, 1));
    run_attempt(1'b0, 1'b0, $urandom_range(0, 4), OPEN_N + 200);
    run_attempt(1'b0, 1'b0, $urandom_range(0, 4), OPEN_N + 200);
    run_attempt(r, ~r, $urandom_range(0, 4), OPEN_N + 200);
    run_attempt(1'b0, 1'b0, $urandom_range(0, 4), OPEN_N + 200);
    run_attempt(1'b0, 1'b0, $urandom_range(0, 4), OPEN_N + 200);
    run_attempt(1'b0, 1'b0, $urandom_range(0, 4), OPEN_N + 200);
  endtask

  task automatic test_register();
    int iv0, mr0, nd;
    enter_entry();
    mr0 = cnt_mr;
    star_key = 1'b1; tick();
    n_chk++;
    if (star !== 1'b1) begin
      n_fail++;
      $display("FAIL star_copy_high: star=%b, required 1", star);
    end
    long_confirm = 1'b1; master_same = 1'b1; tick();
    long_confirm = 1'b0; master_same = 1'b0;
    n_chk++;
    if (mem_rst !== 1'b1 || buff_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_clear: mem_rst=%b buff_rst=%b, required 1 1", mem_rst, buff_rst);
    end
    tick();
    star_key = 1'b0; tick();
    n_chk++;
    if (decision !== 1'b1 || mem_rst !== 1'b0 || star !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_enter: decision=%b mem_rst=%b star=%b, required 1 0 0", decision, mem_rst, star);
    end
    tick();
    nd = $urandom_range(1, 5);
    iv0 = cnt_iv;
    for (int i = 0; i < nd; i++) press_key();
    n_chk++;
    if (cnt_iv - iv0 !== nd || decision !== 1'b1) begin
      n_fail++;
      $display("FAIL reg_digits: %0d input_v decision=%b, required %0d 1", cnt_iv - iv0, decision, nd);
    end
    star_key = 1'b1; tick();
    star_key = 1'b0; tick();
    n_chk++;
    if (decision !== 1'b0 || cnt_mr - mr0 !== 1 || door_open !== 1'b0) begin
      n_fail++;
      $display("FAIL reg_exit: decision=%b mem_rst pulses=%0d door=%b, required 0 1 0",
               decision, cnt_mr - mr0, door_open);
    end
  endtask

  task automatic test_limit_simul();
    int iv0;
    enter_entry();
    iv0 = cnt_iv;
    limit = 1'b1;
    press_key(); press_key();
    n_chk++;
    if (cnt_iv !== iv0) begin
      n_fail++;
      $display("FAIL limit_drop: %0d input_v while full, required 0", cnt_iv - iv0);
    end
    limit = 1'b0;
    press_key();
    n_chk++;
    if (cnt_iv - iv0 !== 1) begin
      n_fail++;
      $display("FAIL limit_release: %0d input_v, required 1", cnt_iv - iv0);
    end
    star_key = 1'b1; tick();
    key_press = 1'b1; star_key = 1'b0; tick();
    key_press = 1'b0;
    n_chk++;
    if (input_v !== 1'b1 || buff_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_digit_first: input_v=%b buff_rst=%b, required 1 0", input_v, buff_rst);
    end
    tick();
    n_chk++;
    if (input_v !== 1'b0 || buff_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_check_cycle: input_v=%b buff_rst=%b, required 0 0", input_v, buff_rst);
    end
    tick();
    fails_m++;
    n_chk++;
    if (buff_rst !== 1'b1 || door_open !== 1'b0 || alarm !== (fails_m == MAXF)) begin
      n_fail++;
      $display("FAIL simul_outcome: buff_rst=%b door=%b alarm=%b, required 1 0 %b",
               buff_rst, door_open, alarm, fails_m == MAXF);
    end
  endtask

  task automatic test_fail_persist();
    run_attempt(1'b0, 1'b0, $urandom_range(0, 3), OPEN_N + 200);
    run_attempt(1'b0, 1'b0, $urandom_range(0, 3), OPEN_N + 200);
  endtask

  task automatic test_reset_mid_open();
    run_attempt(1'b0, 1'b1, 2, 500);
    n_chk++;
    if (door_open !== 1'b1) begin
      n_fail++;
      $display("FAIL open_mid: door=%b at open cycle 500, required 1", door_open);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (door_open !== 1'b0 || alarm !== 1'b0 || decision !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_open: door=%b alarm=%b decision=%b, required 0 0 0", door_open, alarm, decision);
    end
    tick();
    rst = 1'b0;
    fails_m = 0;
    test_shuffle();
  endtask

  initial begin
    rst = 1'b1;
    key_press = 1'b0; star_key = 1'b0; same = 1'b0; master_same = 1'b0;
    limit = 1'b0; long_confirm = 1'b0;
    test_reset();
    test_shuffle();
    test_timeout(1'b0);
    test_unlock();
    test_lockout();
    test_register();
    test_limit_simul();
    test_timeout(1'b1);
    test_fail_persist();
    test_reset_mid_open();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
